// File: rtl/nano_jeff_if.sv
// Memory bus between the nano_jeff core and its external 256-byte memory.
//   iaddr/inst  : instruction fetch address and the byte at that address
//   daddr/data  : data address and the byte at that address
//   wdata/wen   : write data and write enable (written on the rising edge)
// The core uses the master modport and the memory uses the slave modport.
interface nano_jeff_if;
    localparam int unsigned W = 8;

    logic [W-1:0] iaddr;
    logic [W-1:0] daddr;
    logic [W-1:0] wdata;
    logic [W-1:0] inst;
    logic [W-1:0] data;
    logic         wen;

    modport master (
        output iaddr, daddr, wdata, wen,
        input  inst, data
    );

    modport slave (
        input  iaddr, daddr, wdata, wen,
        output inst, data
    );
endinterface

// File: rtl/nano_jeff.sv
// nano_jeff: 8-bit accumulator CPU core with one shared external memory.
// Every instruction is an opcode byte followed by an operand byte, and it takes
// two cycles: FETCH latches the opcode into IR, and EXEC reads the operand
// straight off inst and executes the instruction.
// Ports:
//   clk   : system clock, all state updates on the rising edge
//   reset : synchronous, active-high reset
//   bus   : memory bus (iaddr, daddr, wdata, wen out; inst, data in)
module nano_jeff (
    input  logic          clk,
    input  logic          reset,
    nano_jeff_if.master   bus
);
    localparam int unsigned W = 8;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_XOR = 4'h8;
    localparam logic [3:0] OP_INC = 4'h9;
    localparam logic [3:0] OP_ADI = 4'hA;
    localparam logic [3:0] OP_JMP = 4'hB;
    localparam logic [3:0] OP_JZ  = 4'hC;
    localparam logic [3:0] OP_JC  = 4'hD;
    localparam logic [3:0] OP_JNZ = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t       state, state_n;
    logic [W-1:0] pc, pc_n;
    logic [W-1:0] a, a_n;
    logic [W-1:0] ir, ir_n;
    logic         z, z_n;
    logic         c, c_n;

    logic [W-1:0] daddr_c;
    logic [W-1:0] wdata_c;
    logic         wen_c;
    logic [3:0]   op;
    logic [W:0]   alu;

    // Opcodes with a nonzero upper nibble execute as NOP.
    assign op = (ir[7:4] == 4'h0) ? ir[3:0] : OP_NOP;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            pc    <= '0;
            a     <= '0;
            ir    <= '0;
            z     <= 1'b0;
            c     <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            a     <= a_n;
            ir    <= ir_n;
            z     <= z_n;
            c     <= c_n;
        end
    end

    // Next state, datapath and memory bus controls.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        a_n     = a;
        ir_n    = ir;
        z_n     = z;
        c_n     = c;
        daddr_c = '0;
        wdata_c = a;
        wen_c   = 1'b0;
        alu     = '0;

        unique case (state)
            FETCH: begin
                ir_n    = bus.inst;
                pc_n    = W'(pc + W'(1));
                state_n = EXEC;
            end

            EXEC: begin
                daddr_c = bus.inst;
                pc_n    = W'(pc + W'(1));
                state_n = FETCH;
                unique case (op)
                    OP_LDI: begin
                        a_n = bus.inst;
                        z_n = (bus.inst == '0);
                    end
                    OP_LDA: begin
                        a_n = bus.data;
                        z_n = (bus.data == '0);
                    end
                    OP_STA: begin
                        wen_c = 1'b1;
                    end
                    OP_ADD: begin
                        alu = {1'b0, a} + {1'b0, bus.data};
                        a_n = alu[W-1:0];
                        c_n = alu[W];
                        z_n = (alu[W-1:0] == '0);
                    end
                    OP_SUB: begin
                        // Ninth bit of the extended difference is the borrow.
                        alu = {1'b0, a} - {1'b0, bus.data};
                        a_n = alu[W-1:0];
                        c_n = alu[W];
                        z_n = (alu[W-1:0] == '0);
                    end
                    OP_AND: begin
                        a_n = a & bus.data;
                        z_n = ((a & bus.data) == '0);
                    end
                    OP_OR: begin
                        a_n = a | bus.data;
                        z_n = ((a | bus.data) == '0);
                    end
                    OP_XOR: begin
                        a_n = a ^ bus.data;
                        z_n = ((a ^ bus.data) == '0);
                    end
                    OP_INC: begin
                        // Read-modify-write in one cycle: data is read and
                        // data+1 is written back at the same edge.
                        alu     = {1'b0, bus.data} + (W+1)'(1);
                        wdata_c = alu[W-1:0];
                        wen_c   = 1'b1;
                        c_n     = alu[W];
                        z_n     = (alu[W-1:0] == '0);
                    end
                    OP_ADI: begin
                        alu = {1'b0, a} + {1'b0, bus.inst};
                        a_n = alu[W-1:0];
                        c_n = alu[W];
                        z_n = (alu[W-1:0] == '0);
                    end
                    OP_JMP: pc_n = bus.inst;
                    OP_JZ:  if (z)  pc_n = bus.inst;
                    OP_JC:  if (c)  pc_n = bus.inst;
                    OP_JNZ: if (!z) pc_n = bus.inst;
                    OP_HLT: state_n = HALT;
                    default: ;
                endcase
            end

            HALT: ;

            default: state_n = FETCH;
        endcase
    end

    assign bus.iaddr = pc;
    assign bus.daddr = daddr_c;
    assign bus.wdata = wdata_c;
    // A store in flight must never reach memory while reset is asserted.
    assign bus.wen   = wen_c & ~reset;
endmodule

// File: tb/tb_nano_jeff.sv
module tb_nano_jeff;
    logic clk;
    logic reset;

    nano_jeff_if bus ();

    nano_jeff dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External memory: combinational reads, synchronous write, bulk image load.
    logic [7:0] mem [256];
    logic [7:0] img [256];
    logic       do_load;

    always @(posedge clk) begin
        if (do_load) mem <= img;
        else if (bus.wen) mem[bus.daddr] <= bus.wdata;
    end

    assign bus.inst = mem[bus.iaddr];
    assign bus.data = mem[bus.daddr];

    int n_vec;
    int n_err;

    // Instruction-level reference model.
    logic [7:0] mm [256];
    logic [7:0] m_pc;
    logic [7:0] m_a;
    bit         m_z;
    bit         m_c;
    bit         m_halt;

    task automatic model_step(output bit ew, output logic [7:0] ea, output logic [7:0] ed);
        logic [7:0] opc, opr, pc1, mv, r;
        int t;
        pc1 = m_pc + 8'd1;
        opc = mm[m_pc];
        opr = mm[pc1];
        mv  = mm[opr];
        ew  = 1'b0;
        ea  = opr;
        ed  = m_a;
        m_pc = m_pc + 8'd2;
        if (opc < 8'd16) begin
            case (int'(opc))
                1: begin m_a = opr; m_z = (m_a == 0); end
                2: begin m_a = mv; m_z = (m_a == 0); end
                3: begin ew = 1'b1; mm[opr] = m_a; end
                4, 10: begin
                    t = int'(m_a) + ((opc == 8'd4) ? int'(mv) : int'(opr));
                    m_c = (t > 255);
                    m_a = 8'(t % 256);
                    m_z = (m_a == 0);
                end
                5: begin
                    m_c = (m_a < mv);
                    m_a = 8'((int'(m_a) - int'(mv) + 256) % 256);
                    m_z = (m_a == 0);
                end
                6: begin m_a = m_a & mv; m_z = (m_a == 0); end
                7: begin m_a = m_a | mv; m_z = (m_a == 0); end
                8: begin m_a = m_a ^ mv; m_z = (m_a == 0); end
                9: begin
                    r = 8'((int'(mv) + 1) % 256);
                    m_c = (mv == 8'hFF);
                    m_z = (r == 0);
                    ew = 1'b1;
                    ed = r;
                    mm[opr] = r;
                end
                11: m_pc = opr;
                12: if (m_z)  m_pc = opr;
                13: if (m_c)  m_pc = opr;
                14: if (!m_z) m_pc = opr;
                15: m_halt = 1'b1;
                default: ;
            endcase
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset   = 1'b1;
        do_load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        do_load = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (bus.iaddr !== 8'h00 || bus.wen !== 1'b0) begin
            n_err++;
            $display("FAIL reset: iaddr=%h wen=%b, required iaddr=00 wen=0", bus.iaddr, bus.wen);
        end
        mm = img;
        m_pc = 8'h00; m_a = 8'h00; m_z = 1'b0; m_c = 1'b0; m_halt = 1'b0;
        reset = 1'b0;
    endtask

    // Steps DUT and model one instruction at a time; entered at a negedge in FETCH.
    task automatic run_lockstep(input int max_instr, input bit need_halt, input int halt_cycles);
        logic [7:0] pc0, ea, ed;
        bit ew;
        for (int i = 0; i < max_instr && !m_halt; i++) begin
            n_vec++;
            if (bus.iaddr !== m_pc || bus.wen !== 1'b0 || bus.daddr !== 8'h00) begin
                n_err++;
                $display("FAIL fetch: iaddr=%h wen=%b daddr=%h, required iaddr=%h wen=0 daddr=00",
                         bus.iaddr, bus.wen, bus.daddr, m_pc);
            end
            pc0 = m_pc;
            @(posedge clk);
            @(negedge clk);
            model_step(ew, ea, ed);
            n_vec++;
            if (bus.iaddr !== 8'(pc0 + 8'd1) || bus.wen !== ew || bus.daddr !== ea) begin
                n_err++;
                $display("FAIL exec@%h: iaddr=%h wen=%b daddr=%h, required iaddr=%h wen=%b daddr=%h",
                         pc0, bus.iaddr, bus.wen, bus.daddr, 8'(pc0 + 8'd1), ew, ea);
            end
            if (ew) begin
                n_vec++;
                if (bus.wdata !== ed) begin
                    n_err++;
                    $display("FAIL wdata@%h: got %h, required %h", pc0, bus.wdata, ed);
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        if (need_halt) begin
            n_vec++;
            if (!m_halt) begin
                n_err++;
                $display("FAIL halt_budget: program did not halt within %0d instructions", max_instr);
            end
        end
        if (m_halt) begin
            for (int k = 0; k < halt_cycles; k++) begin
                n_vec++;
                if (bus.iaddr !== m_pc || bus.wen !== 1'b0 || bus.daddr !== 8'h00) begin
                    n_err++;
                    $display("FAIL halted: iaddr=%h wen=%b daddr=%h, required iaddr=%h wen=0 daddr=00",
                             bus.iaddr, bus.wen, bus.daddr, m_pc);
                end
                @(posedge clk);
                @(negedge clk);
            end
        end
        n_vec++;
        for (int k = 0; k < 256; k++) begin
            if (mem[k] !== mm[k]) begin
                n_err++;
                $display("FAIL memory[%h]: got %h, required %h", 8'(k), mem[k], mm[k]);
                break;
            end
        end
    endtask

    task automatic clear_img();
        for (int k = 0; k < 256; k++) img[k] = 8'h00;
    endtask

    task automatic test_inc();
        clear_img();
        img[0] = 8'h09; img[1] = 8'h80; img[2] = 8'h0F; img[3] = 8'h00;
        img[8'h80] = 8'h41;
        test_reset();
        run_lockstep(4, 1'b1, 4);
        n_vec++;
        if (mem[8'h80] !== 8'h42 || bus.iaddr !== 8'h04) begin
            n_err++;
            $display("FAIL inc: mem80=%h iaddr=%h, required mem80=42 iaddr=04", mem[8'h80], bus.iaddr);
        end
    endtask

    task automatic test_add_branch();
        clear_img();
        img[0] = 8'h01; img[1] = 8'hF0;
        img[2] = 8'h04; img[3] = 8'h80;
        img[4] = 8'h03; img[5] = 8'h81;
        img[6] = 8'h0D; img[7] = 8'h10;
        img[8] = 8'h0F;
        img[8'h10] = 8'h0F;
        img[8'h80] = 8'h20;
        test_reset();
        run_lockstep(8, 1'b1, 2);
        n_vec++;
        if (mem[8'h81] !== 8'h10 || bus.iaddr !== 8'h12) begin
            n_err++;
            $display("FAIL add_branch: mem81=%h iaddr=%h, required mem81=10 iaddr=12", mem[8'h81], bus.iaddr);
        end
    endtask

    task automatic test_countdown();
        clear_img();
        img[8'h00] = 8'h01; img[8'h01] = 8'h03;
        img[8'h02] = 8'h03; img[8'h03] = 8'h90;
        img[8'h04] = 8'h02; img[8'h05] = 8'h90;
        img[8'h06] = 8'h05; img[8'h07] = 8'h91;
        img[8'h08] = 8'h03; img[8'h09] = 8'h90;
        img[8'h0A] = 8'h0E; img[8'h0B] = 8'h04;
        img[8'h0C] = 8'h0F;
        img[8'h91] = 8'h01;
        test_reset();
        run_lockstep(30, 1'b1, 3);
        n_vec++;
        if (mem[8'h90] !== 8'h00 || bus.iaddr !== 8'h0E) begin
            n_err++;
            $display("FAIL countdown: mem90=%h iaddr=%h, required mem90=00 iaddr=0e", mem[8'h90], bus.iaddr);
        end
    endtask

    task automatic test_reset_mid_sta();
        clear_img();
        img[0] = 8'h01; img[1] = 8'h55;
        img[2] = 8'h03; img[3] = 8'h80;
        img[8'h80] = 8'h11;
        test_reset();
        run_lockstep(1, 1'b0, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_vec++;
        if (bus.wen !== 1'b0) begin
            n_err++;
            $display("FAIL reset_sta_wen: wen=%b, required 0", bus.wen);
        end
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (bus.iaddr !== 8'h00 || mem[8'h80] !== 8'h11) begin
            n_err++;
            $display("FAIL reset_sta: iaddr=%h mem80=%h, required iaddr=00 mem80=11", bus.iaddr, mem[8'h80]);
        end
        reset = 1'b0;
    endtask

    task automatic test_pc_wrap();
        clear_img();
        img[8'h00] = 8'h0B; img[8'h01] = 8'hF4;
        img[8'h02] = 8'h0D; img[8'h03] = 8'h06;
        img[8'h04] = 8'h0F;
        img[8'h06] = 8'h0F;
        img[8'hF0] = 8'hFF;
        img[8'hF4] = 8'h03; img[8'hF5] = 8'h00;
        img[8'hF6] = 8'h09; img[8'hF7] = 8'hF0;
        img[8'hF8] = 8'h0C; img[8'hF9] = 8'hFC;
        img[8'hFA] = 8'h0F;
        test_reset();
        run_lockstep(12, 1'b1, 2);
        n_vec++;
        if (mem[8'hF0] !== 8'h00 || bus.iaddr !== 8'h08) begin
            n_err++;
            $display("FAIL pc_wrap: memF0=%h iaddr=%h, required memF0=00 iaddr=08", mem[8'hF0], bus.iaddr);
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 8; s++) begin
            for (int k = 0; k < 256; k++) begin
                if (k % 2 == 0 && $urandom_range(0, 9) != 0)
                    img[k] = 8'($urandom_range(0, 14));
                else
                    img[k] = 8'($urandom_range(0, 255));
            end
            test_reset();
            run_lockstep(200, 1'b0, 3);
        end
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        reset   = 1'b1;
        do_load = 1'b0;
        clear_img();
        test_reset();
        test_inc();
        test_add_branch();
        test_countdown();
        test_reset_mid_sta();
        test_pc_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
